// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - wait-state memory responder with request/response handshakes
// One request in flight; wait states precede the access, then the response is held until taken.
module mem_responder #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 16,
  parameter int DEPTH   = 4096,
  parameter int RD_WAIT = 2,
  parameter int WR_WAIT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d, load_cnt;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              mem_we;
  logic              in_range;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] mem_q [DEPTH];

  assign idx      = addr_q[IDX_W-1:0];
  assign in_range = (32'(addr_q) < 32'($unsigned(DEPTH)));
  assign load_cnt = req_we ? 4'(WR_WAIT) : 4'(RD_WAIT);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    mem_we    = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = !rst;
        if (req_valid && req_ready) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = load_cnt;
          state_d = (load_cnt != 4'd0) ? S_WAIT : S_ACCESS;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        // Counter holds the remaining wait cycles including the current one.
        if (cnt_q <= 4'd1) state_d = S_ACCESS;
      end
      S_ACCESS: begin
        if (!in_range) begin
          rdata_d = '0;
          err_d   = 1'b1;
        end else if (we_q) begin
          mem_we  = 1'b1;
          rdata_d = wdata_q;
          err_d   = 1'b0;
        end else begin
          rdata_d = mem_q[idx];
          err_d   = 1'b0;
        end
        state_d = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage is never cleared; reset only blocks a write landing in the same cycle.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem_q[idx] <= wdata_q;
  end

  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - directed self-checking bench for mem_responder
// Unit 0: DEPTH 1024, RD_WAIT 2, WR_WAIT 1. Unit 1: DEPTH 4096, RD_WAIT 0, WR_WAIT 3.
module tb_mem_responder;

  logic             clk;
  logic [1:0]       rst, req_valid, req_we, rsp_ready;
  logic [1:0]       req_ready, rsp_valid, rsp_err, busy;
  logic [1:0][11:0] req_addr;
  logic [1:0][15:0] req_wdata, rsp_rdata;
  int               n_assert = 0;
  int               n_fail   = 0;

  mem_responder #(.DEPTH(1024), .RD_WAIT(2), .WR_WAIT(1)) u0 (
    .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0]), .busy(busy[0])
  );

  mem_responder #(.DEPTH(4096), .RD_WAIT(0), .WR_WAIT(3)) u1 (
    .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1]), .busy(busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Full transaction: accept, n wait states, response held for bp cycles with rsp_ready low.
  task automatic txn(input int u, input bit we, input logic [11:0] a, input logic [15:0] wd,
                     input int n, input int bp, input logic [15:0] exp_d, input bit exp_e);
    chk("idle_req_ready", 32'(req_ready[u]), 1);
    req_valid[u] = 1'b1;
    req_we[u]    = we;
    req_addr[u]  = a;
    req_wdata[u] = wd;
    rsp_ready[u] = (bp == 0);
    tick();
    req_valid[u] = 1'b0;
    req_we[u]    = ~we;
    req_addr[u]  = ~a;
    req_wdata[u] = ~wd;
    for (int k = 1; k < n + 2; k++) begin
      chk("busy_in_flight", 32'(busy[u]), 1);
      chk("no_early_rsp", 32'(rsp_valid[u]), 0);
      chk("ready_low_in_flight", 32'(req_ready[u]), 0);
      tick();
    end
    chk("rsp_valid_at_latency", 32'(rsp_valid[u]), 1);
    chk("rsp_rdata", 32'(rsp_rdata[u]), 32'(exp_d));
    chk("rsp_err", 32'(rsp_err[u]), 32'(exp_e));
    chk("busy_in_resp", 32'(busy[u]), 1);
    for (int b = 1; b < bp; b++) begin
      tick();
      chk("bp_rsp_valid", 32'(rsp_valid[u]), 1);
      chk("bp_rsp_rdata", 32'(rsp_rdata[u]), 32'(exp_d));
      chk("bp_req_ready", 32'(req_ready[u]), 0);
    end
    rsp_ready[u] = 1'b1;
    tick();
    rsp_ready[u] = 1'b0;
    chk("post_rsp_valid", 32'(rsp_valid[u]), 0);
    chk("post_busy", 32'(busy[u]), 0);
    chk("post_req_ready", 32'(req_ready[u]), 1);
    chk("post_rdata_held", 32'(rsp_rdata[u]), 32'(exp_d));
  endtask

  initial begin
    rst       = 2'b11;
    req_valid = '0;
    req_we    = '0;
    rsp_ready = '0;
    req_addr  = '0;
    req_wdata = '0;
    tick();
    for (int u = 0; u < 2; u++) begin
      chk("rst_req_ready", 32'(req_ready[u]), 0);
      chk("rst_rsp_valid", 32'(rsp_valid[u]), 0);
      chk("rst_busy", 32'(busy[u]), 0);
      chk("rst_rsp_rdata", 32'(rsp_rdata[u]), 0);
      chk("rst_rsp_err", 32'(rsp_err[u]), 0);
    end
    tick();
    chk("rst_req_ready_2nd", 32'(req_ready[0]), 0);
    rst = 2'b00;
    tick();
    chk("req_ready_after_rst0", 32'(req_ready[0]), 1);
    chk("req_ready_after_rst1", 32'(req_ready[1]), 1);

    // Unit 0: preload, read with 2 wait states, write/read-back, backpressure, range error
    txn(0, 1'b1, 12'h005, 16'h8123, 1, 0, 16'h8123, 1'b0);
    txn(0, 1'b0, 12'h005, 16'h0000, 2, 0, 16'h8123, 1'b0);
    txn(0, 1'b1, 12'h0A0, 16'hBEEF, 1, 0, 16'hBEEF, 1'b0);
    txn(0, 1'b0, 12'h0A0, 16'h0000, 2, 0, 16'hBEEF, 1'b0);
    txn(0, 1'b1, 12'h010, 16'h1234, 1, 0, 16'h1234, 1'b0);
    txn(0, 1'b0, 12'h010, 16'h0000, 2, 5, 16'h1234, 1'b0);
    txn(0, 1'b1, 12'h000, 16'h0000, 1, 0, 16'h0000, 1'b0);
    txn(0, 1'b1, 12'h400, 16'h5555, 1, 0, 16'h0000, 1'b1);
    txn(0, 1'b0, 12'h000, 16'h0000, 2, 0, 16'h0000, 1'b0);
    txn(0, 1'b0, 12'h400, 16'h0000, 2, 0, 16'h0000, 1'b1);

    // Unit 1: zero-wait read with a second request held off until after the handshake
    txn(1, 1'b1, 12'h020, 16'h0001, 3, 0, 16'h0001, 1'b0);
    txn(1, 1'b1, 12'h030, 16'h0A0A, 3, 0, 16'h0A0A, 1'b0);
    req_valid[1] = 1'b1;
    req_we[1]    = 1'b0;
    req_addr[1]  = 12'h020;
    tick();
    req_addr[1] = 12'h030;
    chk("zw_access_no_rsp", 32'(rsp_valid[1]), 0);
    chk("zw_access_not_ready", 32'(req_ready[1]), 0);
    tick();
    chk("zw_rsp_at_t2", 32'(rsp_valid[1]), 1);
    chk("zw_rsp_rdata", 32'(rsp_rdata[1]), 32'h0001);
    tick();
    chk("zw_still_resp", 32'(rsp_valid[1]), 1);
    chk("zw_holdoff_ready", 32'(req_ready[1]), 0);
    rsp_ready[1] = 1'b1;
    tick();
    rsp_ready[1] = 1'b0;
    chk("zw_idle_between", 32'(busy[1]), 0);
    chk("zw_idle_ready", 32'(req_ready[1]), 1);
    chk("zw_idle_no_rsp", 32'(rsp_valid[1]), 0);
    tick();
    req_valid[1] = 1'b0;
    chk("zw_second_accepted", 32'(busy[1]), 1);
    tick();
    chk("zw_second_rsp", 32'(rsp_valid[1]), 1);
    chk("zw_second_rdata", 32'(rsp_rdata[1]), 32'h0A0A);
    rsp_ready[1] = 1'b1;
    tick();
    rsp_ready[1] = 1'b0;
    chk("zw_second_done", 32'(busy[1]), 0);

    // Unit 1: reset in the second wait cycle of a write
    req_valid[1] = 1'b1;
    req_we[1]    = 1'b1;
    req_addr[1]  = 12'h020;
    req_wdata[1] = 16'h7777;
    tick();
    req_valid[1] = 1'b0;
    chk("rw_busy_wait1", 32'(busy[1]), 1);
    tick();
    rst[1] = 1'b1;
    tick();
    chk("rw_idle_after_rst", 32'(busy[1]), 0);
    chk("rw_no_rsp_in_rst", 32'(rsp_valid[1]), 0);
    chk("rw_not_ready_in_rst", 32'(req_ready[1]), 0);
    rst[1] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("rw_no_rsp_after", 32'(rsp_valid[1]), 0);
    end
    chk("rw_ready_after", 32'(req_ready[1]), 1);
    txn(1, 1'b0, 12'h020, 16'h0000, 0, 0, 16'h0001, 1'b0);

    // Unit 1: reset coinciding with the access cycle of a write
    req_valid[1] = 1'b1;
    req_we[1]    = 1'b1;
    req_addr[1]  = 12'h020;
    req_wdata[1] = 16'h7777;
    tick();
    req_valid[1] = 1'b0;
    tick();
    tick();
    tick();
    chk("ra_in_access_no_rsp", 32'(rsp_valid[1]), 0);
    rst[1] = 1'b1;
    tick();
    rst[1] = 1'b0;
    chk("ra_idle_after_rst", 32'(busy[1]), 0);
    tick();
    chk("ra_no_rsp", 32'(rsp_valid[1]), 0);
    txn(1, 1'b0, 12'h020, 16'h0000, 0, 0, 16'h0001, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
